// File: rtl/mac2fifo_demux_pkg.sv
// Shared types and constants for the UDP RX payload demux into per-channel FIFOs.
package mac2fifo_demux_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHK,
    ST_HDR,
    ST_DATA,
    ST_DONE
  } st_e;

  localparam int MAX_LEN_DEF  = 1472;
  localparam int CH_HDR_BYTES = 1;

endpackage

// File: rtl/mac2fifo_demux_udp_rd_stage.sv
// RAM read-address counter plus a one-entry hold register that absorbs the byte in flight
// when the selected FIFO stalls, giving 1 byte/clk with no loss or duplication.
module udp_rd_stage
  import mac2fifo_demux_pkg::*;
#(
  parameter int ADDR_W = 11,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              hdr_adv,
  input  logic              rd_go,
  input  logic              wr_go,
  input  logic              full_ch,
  input  logic [LEN_W-1:0]  len,
  input  logic [7:0]        udp_rxd,
  output logic [ADDR_W-1:0] udp_rx_addr,
  output logic              fire,
  output logic [7:0]        wr_data,
  output logic [LEN_W-1:0]  wr_cnt
);

  logic [LEN_W-1:0] addr_p0;
  logic             rd_vld_p1;
  logic             hold_vld_p1;
  logic [7:0]       hold_p1;
  logic             hold_full;
  logic             issue;

  // A returning RAM byte counts as "held" in its arrival cycle; it only moves into
  // hold_p1 when it cannot be written straight away.
  assign hold_full   = rd_vld_p1 | hold_vld_p1;
  assign fire        = wr_go & hold_full & ~full_ch;
  assign issue       = rd_go & (addr_p0 < len) & (~hold_full | fire);
  assign wr_data     = hold_vld_p1 ? hold_p1 : udp_rxd;
  assign udp_rx_addr = addr_p0[ADDR_W-1:0];

  // ---- stage p0: address issue / p1: data return and hold ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_p0     <= '0;
      rd_vld_p1   <= 1'b0;
      hold_vld_p1 <= 1'b0;
      wr_cnt      <= '0;
    end else if (clr) begin
      addr_p0     <= '0;
      rd_vld_p1   <= 1'b0;
      hold_vld_p1 <= 1'b0;
      wr_cnt      <= '0;
    end else begin
      if (hdr_adv || issue)
        addr_p0 <= addr_p0 + LEN_W'(1);
      rd_vld_p1   <= issue;
      hold_vld_p1 <= hold_full & ~fire;
      if (fire)
        wr_cnt <= wr_cnt + LEN_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rd_vld_p1 && !fire)
      hold_p1 <= udp_rxd;
  end

endmodule

// File: rtl/mac2fifo_demux.sv
// Drains one UDP payload from the MAC RX RAM into the FIFO named by its first byte,
// with length/channel checks, abort detection and the fs/fd handshake.
module mac2fifo_demux
  import mac2fifo_demux_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int CH_W    = 2,
  parameter int ADDR_W  = 11,
  parameter int LEN_W   = 16,
  parameter int MAX_LEN = MAX_LEN_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fs,
  output logic              fd,
  input  logic [LEN_W-1:0]  udp_rx_len,
  output logic [ADDR_W-1:0] udp_rx_addr,
  input  logic [7:0]        udp_rxd,
  output logic [7:0]        fifo_txd,
  output logic [NCH-1:0]    fifo_txen,
  input  logic [NCH-1:0]    fifo_full,
  output logic [LEN_W-1:0]  dev_rx_len,
  output logic [CH_W-1:0]   dev_rx_ch,
  output logic              err_len,
  output logic              err_ch,
  output logic              err_abort,
  output logic [15:0]       frm_cnt
);

  st_e              st_q, st_n;
  logic             fs_q;
  logic [LEN_W-1:0] len_q;
  logic [CH_W-1:0]  ch_q;
  logic             fs_rise, len_bad, ch_bad, wr_last;
  logic             clr, hdr_adv, rd_go, wr_go, full_ch, fire;
  logic [7:0]       wr_data;
  logic [LEN_W-1:0] wr_cnt;
  logic             good_done, err_done, abort;

  assign fs_rise = fs & ~fs_q;
  assign len_bad = (len_q == '0) || (len_q > LEN_W'(MAX_LEN));
  assign ch_bad  = udp_rxd >= 8'(NCH);
  assign wr_last = (wr_cnt + LEN_W'(CH_HDR_BYTES + 1)) == len_q;
  assign full_ch = fifo_full[ch_q];

  udp_rd_stage #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_rd (
    .clk         (clk),
    .rst         (rst),
    .clr         (clr),
    .hdr_adv     (hdr_adv),
    .rd_go       (rd_go),
    .wr_go       (wr_go),
    .full_ch     (full_ch),
    .len         (len_q),
    .udp_rxd     (udp_rxd),
    .udp_rx_addr (udp_rx_addr),
    .fire        (fire),
    .wr_data     (wr_data),
    .wr_cnt      (wr_cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) st_q <= ST_IDLE;
    else     st_q <= st_n;
  end

  // The last write beats a simultaneous fs fall, so DATA checks completion first.
  always_comb begin
    st_n = st_q;
    case (st_q)
      ST_IDLE: if (fs_rise) st_n = ST_CHK;
      ST_CHK: begin
        if (!fs)         st_n = ST_IDLE;
        else if (len_bad) st_n = ST_DONE;
        else             st_n = ST_HDR;
      end
      ST_HDR: begin
        if (!fs)                                    st_n = ST_IDLE;
        else if (ch_bad)                            st_n = ST_DONE;
        else if (len_q == LEN_W'(CH_HDR_BYTES))     st_n = ST_DONE;
        else                                        st_n = ST_DATA;
      end
      ST_DATA: begin
        if (fire && wr_last) st_n = ST_DONE;
        else if (!fs)        st_n = ST_IDLE;
      end
      ST_DONE: if (!fs) st_n = ST_IDLE;
      default: st_n = ST_IDLE;
    endcase
  end

  always_comb begin
    clr     = 1'b0;
    hdr_adv = 1'b0;
    rd_go   = 1'b0;
    wr_go   = 1'b0;
    fd      = 1'b0;
    case (st_q)
      ST_IDLE: clr = 1'b1;
      ST_CHK:  hdr_adv = fs & ~len_bad;
      ST_HDR:  rd_go = fs;
      ST_DATA: begin
        rd_go = fs;
        wr_go = fs | wr_last;
      end
      ST_DONE: begin
        clr = 1'b1;
        fd  = 1'b1;
      end
      default: clr = 1'b1;
    endcase
  end

  assign fifo_txen = fire ? (NCH'(1) << ch_q) : '0;
  assign fifo_txd  = fire ? wr_data : 8'h00;

  assign good_done = (st_q == ST_HDR && fs && !ch_bad && len_q == LEN_W'(CH_HDR_BYTES)) ||
                     (st_q == ST_DATA && fire && wr_last);
  assign err_done  = (st_q == ST_CHK && fs && len_bad) || (st_q == ST_HDR && fs && ch_bad);
  assign abort     = (st_q inside {ST_CHK, ST_HDR, ST_DATA}) && (st_n == ST_IDLE);

  // fs_q resets high so an fs still held across reset is not mistaken for a new frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fs_q       <= 1'b1;
      len_q      <= '0;
      ch_q       <= '0;
      err_len    <= 1'b0;
      err_ch     <= 1'b0;
      err_abort  <= 1'b0;
      dev_rx_len <= '0;
      dev_rx_ch  <= '0;
      frm_cnt    <= '0;
    end else begin
      fs_q      <= fs;
      err_len   <= (st_q == ST_CHK) && fs && len_bad;
      err_ch    <= (st_q == ST_HDR) && fs && ch_bad;
      err_abort <= abort;
      if (st_q == ST_IDLE && fs_rise)
        len_q <= udp_rx_len;
      if (st_q == ST_HDR && fs && !ch_bad)
        ch_q <= udp_rxd[CH_W-1:0];
      if (good_done) begin
        dev_rx_len <= len_q - LEN_W'(CH_HDR_BYTES);
        dev_rx_ch  <= (st_q == ST_HDR) ? udp_rxd[CH_W-1:0] : ch_q;
        frm_cnt    <= frm_cnt + 16'd1;
      end else if (err_done) begin
        dev_rx_len <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mac2fifo_demux.sv
// Directed bench: RAM model, FIFO write monitor and a linear sequence of frames.
module tb_mac2fifo_demux;
  localparam int NCH = 4, CH_W = 2, ADDR_W = 11, LEN_W = 16;

  logic              clk = 1'b0;
  logic              rst, fs;
  logic              fd;
  logic [LEN_W-1:0]  udp_rx_len;
  logic [ADDR_W-1:0] udp_rx_addr;
  logic [7:0]        udp_rxd;
  logic [7:0]        fifo_txd;
  logic [NCH-1:0]    fifo_txen, fifo_full;
  logic [LEN_W-1:0]  dev_rx_len;
  logic [CH_W-1:0]   dev_rx_ch;
  logic              err_len, err_ch, err_abort;
  logic [15:0]       frm_cnt;

  mac2fifo_demux #(.NCH(NCH), .CH_W(CH_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .MAX_LEN(1472)) dut (
    .clk(clk), .rst(rst), .fs(fs), .fd(fd), .udp_rx_len(udp_rx_len), .udp_rx_addr(udp_rx_addr),
    .udp_rxd(udp_rxd), .fifo_txd(fifo_txd), .fifo_txen(fifo_txen), .fifo_full(fifo_full),
    .dev_rx_len(dev_rx_len), .dev_rx_ch(dev_rx_ch), .err_len(err_len), .err_ch(err_ch),
    .err_abort(err_abort), .frm_cnt(frm_cnt)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:2047];
  always @(posedge clk) udp_rxd <= mem[udp_rx_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [3:0] wr_en_q[$];
  logic [7:0] wr_d_q[$];
  int         wr_t_q[$];
  int n_elen = 0, n_ech = 0, n_eab = 0;
  always @(negedge clk) begin
    if (fifo_txen != '0) begin
      wr_en_q.push_back(fifo_txen);
      wr_d_q.push_back(fifo_txd);
      wr_t_q.push_back(cyc);
    end
    if (err_len)   n_elen <= n_elen + 1;
    if (err_ch)    n_ech  <= n_ech + 1;
    if (err_abort) n_eab  <= n_eab + 1;
  end

  int tests = 0, fails = 0;
  int t0, wb, el, ec, ea;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [7:0] chb, input logic [7:0] seed, input int n);
    mem[0] = chb;
    for (int i = 1; i < n; i++) mem[i] = seed + 8'(i);
  endtask

  task automatic start(input logic [15:0] len);
    wb = wr_d_q.size();
    el = n_elen; ec = n_ech; ea = n_eab;
    udp_rx_len = len;
    fs = 1'b1;
    t0 = cyc;
  endtask

  task automatic step_to(input int target);
    while (cyc < target) begin @(posedge clk); #1; end
  endtask

  task automatic wait_fd(input string tag);
    int i = 0;
    while (!fd && i < 3000) begin @(posedge clk); #1; i++; end
    chk({tag, "_fd"}, 32'(fd), 32'd1);
  endtask

  task automatic end_frame(input string tag);
    @(negedge clk);
    fs = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_fd_low"}, 32'(fd), 32'd0);
  endtask

  task automatic chk_wr(input string tag, input int n, input logic [3:0] en, input logic [7:0] seed);
    chk({tag, "_nwr"}, 32'(wr_d_q.size() - wb), 32'(n));
    if (wr_d_q.size() >= wb + n)
      for (int k = 0; k < n; k++)
        chk({tag, "_byte"}, {20'd0, wr_en_q[wb+k], wr_d_q[wb+k]}, {20'd0, en, seed + 8'(k + 1)});
  endtask

  task automatic chk_err(input string tag, input int dl, input int dc, input int da);
    chk({tag, "_err_len"}, 32'(n_elen - el), 32'(dl));
    chk({tag, "_err_ch"}, 32'(n_ech - ec), 32'(dc));
    chk({tag, "_err_abort"}, 32'(n_eab - ea), 32'(da));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
    rst = 1'b1; fs = 1'b0; fifo_full = '0; udp_rx_len = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_fd", 32'(fd), 0);
    chk("rst_txen", 32'(fifo_txen), 0);
    chk("rst_addr", 32'(udp_rx_addr), 0);
    chk("rst_outs", {dev_rx_len, frm_cnt}, 0);
    chk("rst_err", {29'd0, err_len, err_ch, err_abort}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // channel 2, never full: 8 back-to-back writes starting 3 clk after fs
    load(8'h02, 8'h00, 9);
    start(16'd9);
    wait_fd("t1");
    end_frame("t1");
    chk_wr("t1", 8, 4'b0100, 8'h00);
    if (wr_t_q.size() >= wb + 8)
      for (int k = 0; k < 8; k++) chk("t1_time", 32'(wr_t_q[wb+k] - t0), 32'(3 + k));
    chk("t1_dev_len", 32'(dev_rx_len), 8);
    chk("t1_dev_ch", 32'(dev_rx_ch), 2);
    chk("t1_frm", 32'(frm_cnt), 1);
    chk_err("t1", 0, 0, 0);

    // channel 0 with full during DATA clocks 4-6
    load(8'h00, 8'h10, 9);
    start(16'd9);
    step_to(t0 + 6); fifo_full = 4'b0001;
    step_to(t0 + 9); fifo_full = 4'b0000;
    wait_fd("t2");
    end_frame("t2");
    chk_wr("t2", 8, 4'b0001, 8'h10);
    if (wr_t_q.size() >= wb + 8)
      for (int k = 0; k < 8; k++) chk("t2_time", 32'(wr_t_q[wb+k] - t0), 32'((k < 3) ? 3 + k : 6 + k));
    chk("t2_dev_len", 32'(dev_rx_len), 8);
    chk("t2_dev_ch", 32'(dev_rx_ch), 0);
    chk("t2_frm", 32'(frm_cnt), 2);

    // len = 0
    start(16'd0);
    wait_fd("t3");
    end_frame("t3");
    chk_wr("t3", 0, 4'b0000, 8'h00);
    chk_err("t3", 1, 0, 0);
    chk("t3_dev_len", 32'(dev_rx_len), 0);
    chk("t3_frm", 32'(frm_cnt), 2);

    // len = 1: channel byte only, good frame with no writes
    load(8'h03, 8'h00, 1);
    start(16'd1);
    wait_fd("t4");
    end_frame("t4");
    chk_wr("t4", 0, 4'b0000, 8'h00);
    chk_err("t4", 0, 0, 0);
    chk("t4_dev_ch", 32'(dev_rx_ch), 3);
    chk("t4_frm", 32'(frm_cnt), 3);

    // len = MAX_LEN + 1
    start(16'd1473);
    wait_fd("t5");
    end_frame("t5");
    chk_wr("t5", 0, 4'b0000, 8'h00);
    chk_err("t5", 1, 0, 0);
    chk("t5_frm", 32'(frm_cnt), 3);
    chk("t5_dev_ch", 32'(dev_rx_ch), 3);

    // len = MAX_LEN is still accepted
    load(8'h01, 8'h00, 1472);
    start(16'd1472);
    wait_fd("t6");
    end_frame("t6");
    chk("t6_nwr", 32'(wr_d_q.size() - wb), 1471);
    chk("t6_dev_len", 32'(dev_rx_len), 1471);
    chk("t6_frm", 32'(frm_cnt), 4);
    chk_err("t6", 0, 0, 0);

    // bad channel id
    load(8'h07, 8'h00, 5);
    start(16'd5);
    wait_fd("t7");
    end_frame("t7");
    chk_wr("t7", 0, 4'b0000, 8'h00);
    chk_err("t7", 0, 1, 0);
    chk("t7_dev_len", 32'(dev_rx_len), 0);
    chk("t7_frm", 32'(frm_cnt), 4);

    // fs dropped after 3 writes
    load(8'h03, 8'h20, 9);
    start(16'd9);
    step_to(t0 + 6); fs = 1'b0;
    @(negedge clk);
    chk("t8_txen_at_drop", 32'(fifo_txen), 0);
    step_to(t0 + 8);
    chk("t8_fd", 32'(fd), 0);
    chk_wr("t8", 3, 4'b1000, 8'h20);
    chk_err("t8", 0, 0, 1);
    chk("t8_frm", 32'(frm_cnt), 4);

    // clean frame after the abort
    load(8'h01, 8'h30, 5);
    start(16'd5);
    wait_fd("t9");
    end_frame("t9");
    chk_wr("t9", 4, 4'b0010, 8'h30);
    chk("t9_dev_len", 32'(dev_rx_len), 4);
    chk("t9_dev_ch", 32'(dev_rx_ch), 1);
    chk("t9_frm", 32'(frm_cnt), 5);

    // reset in the middle of DATA
    load(8'h02, 8'h40, 9);
    start(16'd9);
    step_to(t0 + 5);
    rst = 1'b1;
    #1;
    chk("t10_txen", 32'(fifo_txen), 0);
    chk("t10_addr", 32'(udp_rx_addr), 0);
    chk("t10_outs", {dev_rx_len, frm_cnt}, 0);
    chk("t10_fd", 32'(fd), 0);
    wb = wr_d_q.size();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("t10_no_writes", 32'(wr_d_q.size() - wb), 0);
    chk("t10_fd_idle", 32'(fd), 0);
    fs = 1'b0;
    @(posedge clk); #1;

    load(8'h02, 8'h50, 9);
    start(16'd9);
    wait_fd("t11");
    end_frame("t11");
    chk_wr("t11", 8, 4'b0100, 8'h50);
    chk("t11_dev_len", 32'(dev_rx_len), 8);
    chk("t11_frm", 32'(frm_cnt), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
